// File: rtl/roce_tx_pattern_source_64_if.sv
// AXI-Stream bundle carrying the pattern payload toward the RoCE TX header producer.
interface roce_tx_pattern_source_64_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/roce_tx_pattern_source_64.sv
// Deterministic AXI-Stream payload source: emits dma_transfer_length bytes per start edge.
// Optional macro ROCE_PATTERN_SOURCE_PRBS_EN swaps the offset pattern for a 31-bit LFSR.
module roce_tx_pattern_source_64 #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_transfer,
  input  logic [31:0]                  dma_transfer_length,
  roce_tx_pattern_source_64_if.master  m_axis,
  output logic                         busy,
  output logic                         done,
  output logic                         error_zero_length,
  output logic [31:0]                  bytes_sent
);

  if (DATA_WIDTH != 64 || KEEP_WIDTH != 8) begin : g_width_check
    $error("roce_tx_pattern_source_64 supports only DATA_WIDTH=64, KEEP_WIDTH=8");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic        start_d;
  logic        start_event;
  logic        accept;
  logic        zero_hit;
  logic        hs;
  logic        last;
  logic [31:0] len_reg;
  logic [31:0] offset;
  logic [31:0] rem;
  logic [32:0] end_sum;
  logic [7:0]  keep;
  logic [3:0]  keep_bytes;
  logic [31:0] pat;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    zero_hit    = 1'b0;
    start_event = start_transfer && !start_d;
    // 33-bit sum keeps lengths close to 2^32-1 from wrapping the last-beat test
    end_sum     = {1'b0, offset} + 33'd8;
    last        = (end_sum >= {1'b0, len_reg});
    rem         = len_reg - offset;
    keep        = '1;
    keep_bytes  = 4'd8;
    if (last && (rem < 32'd8)) begin
      keep       = 8'((9'd1 << rem[2:0]) - 9'd1);
      keep_bytes = {1'b0, rem[2:0]};
    end
    hs = (state_q == SEND) && m_axis.tready;
    case (state_q)
      IDLE: begin
        if (start_event) begin
          if (dma_transfer_length == '0) begin
            zero_hit = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (hs && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d           <= 1'b0;
      done              <= 1'b0;
      error_zero_length <= 1'b0;
      len_reg           <= '0;
      offset            <= '0;
      bytes_sent        <= '0;
    end else begin
      start_d           <= start_transfer;
      done              <= hs && last;
      error_zero_length <= zero_hit;
      if (accept) begin
        len_reg    <= dma_transfer_length;
        offset     <= '0;
        bytes_sent <= '0;
      end else if (hs) begin
        offset     <= offset + 32'd8;
        bytes_sent <= bytes_sent + 32'(keep_bytes);
      end
    end
  end

`ifdef ROCE_PATTERN_SOURCE_PRBS_EN
  logic [31:0] lfsr;

  // Fibonacci x^31+x^28+1, shifting toward the MSB; bit 31 stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lfsr <= '0;
    else if (accept) lfsr <= 32'h7FFF_FFFF;
    else if (hs)     lfsr <= {1'b0, lfsr[29:0], lfsr[30] ^ lfsr[27]};
  end

  assign pat = lfsr;
`else
  assign pat = offset;
`endif

  assign busy          = (state_q == SEND);
  assign m_axis.tvalid = busy;
  assign m_axis.tdata  = busy ? {~pat, pat} : '0;
  assign m_axis.tkeep  = busy ? keep : '0;
  assign m_axis.tlast  = busy && last;
  assign m_axis.tuser  = 1'b0;

endmodule

// File: tb/tb_roce_tx_pattern_source_64.sv
// Scoreboard bench for roce_tx_pattern_source_64: directed transfers, stalls, restarts and reset.
module tb_roce_tx_pattern_source_64;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        start_transfer;
  logic [31:0] dma_transfer_length;
  logic        busy;
  logic        done;
  logic        error_zero_length;
  logic [31:0] bytes_sent;
  logic        toggle_ready;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb[$];

  roce_tx_pattern_source_64_if m_axis ();

  roce_tx_pattern_source_64 #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_transfer      (start_transfer),
    .dma_transfer_length (dma_transfer_length),
    .m_axis              (m_axis),
    .busy                (busy),
    .done                (done),
    .error_zero_length   (error_zero_length),
    .bytes_sent          (bytes_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
    beat_t b;
    b.d = d;
    b.k = k;
    b.l = l;
    sb.push_back(b);
  endtask

  task automatic push_model(input logic [31:0] len);
    logic [31:0] off;
    logic [31:0] rem;
    logic [31:0] lf;
    beat_t       b;
    off = '0;
    lf  = 32'h7FFF_FFFF;
    while (off < len) begin
      rem = len - off;
      b.k = (rem >= 32'd8) ? 8'hFF : 8'((16'd1 << rem) - 16'd1);
      b.l = (rem <= 32'd8);
`ifdef ROCE_PATTERN_SOURCE_PRBS_EN
      b.d = {~lf, lf};
      lf  = {1'b0, lf[29:0], lf[30] ^ lf[27]};
`else
      b.d = {~off, off};
`endif
      sb.push_back(b);
      off += 32'd8;
    end
  endtask

  // Rising edge on start, sampled at the following posedge; returns one step after that edge.
  task automatic start_edge(input logic [31:0] len);
    @(posedge clk); #1;
    dma_transfer_length = len;
    start_transfer      = 1'b1;
    chk("tvalid_before_edge", {63'd0, m_axis.tvalid}, 64'd0);
    @(posedge clk); #1;
    start_transfer = 1'b0;
  endtask

  task automatic wait_done(input logic [31:0] len, input int budget);
    int cnt;
    cnt = 0;
    while (1) begin
      @(posedge clk); #1;
      if (done) break;
      cnt++;
      if (cnt >= budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout actual=no_done expected=done_within_%0d", budget);
        return;
      end
    end
    chk("bytes_sent", {32'd0, bytes_sent}, {32'd0, len});
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("tvalid_after_done", {63'd0, m_axis.tvalid}, 64'd0);
    chk("beats_left", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
    chk("done_single_pulse", {63'd0, done}, 64'd0);
  endtask

  // tready driver: constant 1, or toggling every cycle during the stall test
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis.tready = toggle_ready ? ~m_axis.tready : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake and watches stalled beats for stability
  initial begin
    beat_t b;
    beat_t held;
    logic  stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_tvalid", {63'd0, m_axis.tvalid}, 64'd1);
          chk("stall_tdata", m_axis.tdata, held.d);
          chk("stall_tkeep_tlast", {55'd0, m_axis.tkeep, m_axis.tlast}, {55'd0, held.k, held.l});
        end
        if (m_axis.tvalid && m_axis.tready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat actual=%h expected=none", m_axis.tdata);
          end else begin
            b = sb.pop_front();
            chk("beat_tdata", m_axis.tdata, b.d);
            chk("beat_tkeep", {56'd0, m_axis.tkeep}, {56'd0, b.k});
            chk("beat_tlast", {63'd0, m_axis.tlast}, {63'd0, b.l});
            chk("beat_tuser", {63'd0, m_axis.tuser}, 64'd0);
          end
        end
        stalled = m_axis.tvalid && !m_axis.tready;
        held.d  = m_axis.tdata;
        held.k  = m_axis.tkeep;
        held.l  = m_axis.tlast;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n               = 1'b0;
    start_transfer      = 1'b0;
    dma_transfer_length = '0;
    toggle_ready        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
    chk("rst_tdata", m_axis.tdata, 64'd0);
    chk("rst_busy_done_err", {61'd0, busy, done, error_zero_length}, 64'd0);
    chk("rst_bytes_sent", {32'd0, bytes_sent}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // length 20: three beats, partial last
`ifdef ROCE_PATTERN_SOURCE_PRBS_EN
    push_model(32'd20);
`else
    push(64'hFFFFFFFF_00000000, 8'hFF, 1'b0);
    push(64'hFFFFFFF7_00000008, 8'hFF, 1'b0);
    push(64'hFFFFFFEF_00000010, 8'h0F, 1'b1);
`endif
    start_edge(32'd20);
    chk("tvalid_latency", {63'd0, m_axis.tvalid}, 64'd1);
    chk("busy_in_send", {63'd0, busy}, 64'd1);
    wait_done(32'd20, 20);

    // length 16: exact multiple, full last beat
`ifdef ROCE_PATTERN_SOURCE_PRBS_EN
    push_model(32'd16);
`else
    push(64'hFFFFFFFF_00000000, 8'hFF, 1'b0);
    push(64'hFFFFFFF7_00000008, 8'hFF, 1'b1);
`endif
    start_edge(32'd16);
    wait_done(32'd16, 20);

    // length 1: single byte
`ifdef ROCE_PATTERN_SOURCE_PRBS_EN
    push_model(32'd1);
`else
    push(64'hFFFFFFFF_00000000, 8'h01, 1'b1);
`endif
    start_edge(32'd1);
    wait_done(32'd1, 20);

    // length 0: error pulse only, bytes_sent keeps 1
    start_edge(32'd0);
    chk("zero_err_pulse", {63'd0, error_zero_length}, 64'd1);
    chk("zero_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
    chk("zero_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk("zero_err_single", {63'd0, error_zero_length}, 64'd0);
    chk("zero_tvalid_later", {63'd0, m_axis.tvalid}, 64'd0);
    chk("zero_bytes_kept", {32'd0, bytes_sent}, 64'd1);

    // length 64 with tready toggling
    toggle_ready = 1'b1;
    push_model(32'd64);
    start_edge(32'd64);
    wait_done(32'd64, 60);
    toggle_ready = 1'b0;
    @(posedge clk); #1;

    // length 40 with a second edge and a length change mid-transfer
    push_model(32'd40);
    start_edge(32'd40);
    @(posedge clk); #1;
    dma_transfer_length = 32'd8;
    start_transfer      = 1'b1;
    @(posedge clk); #1;
    start_transfer = 1'b0;
    wait_done(32'd40, 20);

    // start held high across done must not retrigger
    push_model(32'd8);
    @(posedge clk); #1;
    dma_transfer_length = 32'd8;
    start_transfer      = 1'b1;
    wait_done(32'd8, 20);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("held_start_no_retrigger", {62'd0, m_axis.tvalid, busy}, 64'd0);
    end
    start_transfer = 1'b0;
    push_model(32'd8);
    start_edge(32'd8);
    chk("restart_tvalid", {63'd0, m_axis.tvalid}, 64'd1);
    wait_done(32'd8, 20);

    // asynchronous reset during beat 2 of a 40-byte transfer
    push_model(32'd40);
    start_edge(32'd40);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
    chk("async_rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("async_rst_bytes_sent", {32'd0, bytes_sent}, 64'd0);
    chk("async_rst_tdata", m_axis.tdata, 64'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef ROCE_PATTERN_SOURCE_PRBS_EN
    push_model(32'd8);
`else
    push(64'hFFFFFFFF_00000000, 8'hFF, 1'b1);
`endif
    start_edge(32'd8);
    chk("post_rst_tvalid", {63'd0, m_axis.tvalid}, 64'd1);
    wait_done(32'd8, 20);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
